// File: rtl/sda_kernel_ctrl_pkg.sv
// sda_kernel_ctrl_pkg: shared encodings for the SDAccel kernel control master.
package sda_kernel_ctrl_pkg;
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam int CTRL_REG_OFFSET  = 0;
    localparam int AP_START_BIT     = 0;
    localparam int AP_DONE_BIT      = 1;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_POLL_GAP, S_RSP} state_e;
endpackage

// File: rtl/sda_ctrl_poll_timer.sv
// sda_ctrl_poll_timer: saturating cycle counter, cleared by load, expires at LIMIT.
module sda_ctrl_poll_timer #(
    parameter int          W     = 32,
    parameter int unsigned LIMIT = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic tick_i,
    output logic expire_o
);
    logic [W-1:0] cnt_q;
    assign expire_o = cnt_q >= W'(LIMIT);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (load_i) cnt_q <= '0;
        else if (tick_i && !expire_o) cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/sda_kernel_ctrl_master.sv
// sda_kernel_ctrl_master: AXI4-Lite initiator for an SDAccel s_axi_control slave.
// Optional RUN poll timeout enabled by defining SDA_CTRL_MASTER_TIMEOUT_EN.
module sda_kernel_ctrl_master
    import sda_kernel_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int POLL_GAP       = 15,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] m_axi_control_AWADDR,
    output logic                  m_axi_control_AWVALID,
    input  logic                  m_axi_control_AWREADY,
    output logic [31:0]           m_axi_control_WDATA,
    output logic [3:0]            m_axi_control_WSTRB,
    output logic                  m_axi_control_WVALID,
    input  logic                  m_axi_control_WREADY,
    input  logic [1:0]            m_axi_control_BRESP,
    input  logic                  m_axi_control_BVALID,
    output logic                  m_axi_control_BREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_control_ARADDR,
    output logic                  m_axi_control_ARVALID,
    input  logic                  m_axi_control_ARREADY,
    input  logic [31:0]           m_axi_control_RDATA,
    input  logic [1:0]            m_axi_control_RRESP,
    input  logic                  m_axi_control_RVALID,
    output logic                  m_axi_control_RREADY
);
    state_e                state_q;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q, rdata_q;
    logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q, err_q, cmd_ready_q;
    logic gap_exp, to_exp, b_err, r_err, aw_left, w_left;

    assign b_err   = err_q | (m_axi_control_BRESP != AXI_RESP_OKAY);
    assign r_err   = err_q | (m_axi_control_RRESP != AXI_RESP_OKAY);
    assign aw_left = awvalid_q & ~m_axi_control_AWREADY;
    assign w_left  = wvalid_q & ~m_axi_control_WREADY;

    // Gap counter runs only inside POLL_GAP; LIMIT is the last gap cycle index.
    sda_ctrl_poll_timer #(.W(32), .LIMIT(POLL_GAP > 0 ? POLL_GAP - 1 : 0)) u_gap (
        .clk_i(ap_clk), .rst_ni(ap_rst_n),
        .load_i(state_q != S_POLL_GAP), .tick_i(state_q == S_POLL_GAP), .expire_o(gap_exp)
    );
`ifdef SDA_CTRL_MASTER_TIMEOUT_EN
    sda_ctrl_poll_timer #(.W(32), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i(ap_clk), .rst_ni(ap_rst_n),
        .load_i(state_q == S_IDLE), .tick_i(state_q inside {S_RD_AR, S_RD_R, S_POLL_GAP}),
        .expire_o(to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    cmd_ready_q <= 1'b0;
                    op_q        <= cmd_op;
                    err_q       <= 1'b0;
                    rdata_q     <= '0;
                    addr_q      <= (cmd_op == OP_RUN) ? ADDR_WIDTH'(CTRL_REG_OFFSET) : cmd_addr;
                    wdata_q     <= (cmd_op == OP_RUN) ? (32'd1 << AP_START_BIT) : cmd_wdata;
                    case (cmd_op)
                        OP_WRITE, OP_RUN: begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR;
                        end
                        OP_READ: begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_AR;
                        end
                        default: begin
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RSP;
                        end
                    endcase
                end
                S_WR: begin
                    awvalid_q <= aw_left;
                    wvalid_q  <= w_left;
                    if (!aw_left && !w_left) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_B;
                    end
                end
                S_WR_B: if (m_axi_control_BVALID) begin
                    bready_q <= 1'b0;
                    err_q    <= b_err;
                    if (op_q == OP_RUN && !b_err) begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RD_AR;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end
                end
                S_RD_AR: if (m_axi_control_ARREADY) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_RD_R;
                end
                S_RD_R: if (m_axi_control_RVALID) begin
                    rready_q <= 1'b0;
                    rdata_q  <= m_axi_control_RDATA;
                    err_q    <= r_err;
                    if (op_q != OP_RUN || r_err || m_axi_control_RDATA[AP_DONE_BIT] || to_exp) begin
                        err_q       <= r_err | to_exp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else if (POLL_GAP == 0) begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RD_AR;
                    end else state_q <= S_POLL_GAP;
                end
                S_POLL_GAP: if (to_exp) begin
                    err_q       <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end else if (gap_exp) begin
                    arvalid_q <= 1'b1;
                    state_q   <= S_RD_AR;
                end
                S_RSP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready             = cmd_ready_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_rdata             = rdata_q;
    assign rsp_err               = err_q;
    assign m_axi_control_AWADDR  = addr_q;
    assign m_axi_control_AWVALID = awvalid_q;
    assign m_axi_control_WDATA   = wdata_q;
    assign m_axi_control_WSTRB   = 4'hF;
    assign m_axi_control_WVALID  = wvalid_q;
    assign m_axi_control_BREADY  = bready_q;
    assign m_axi_control_ARADDR  = addr_q;
    assign m_axi_control_ARVALID = arvalid_q;
    assign m_axi_control_RREADY  = rready_q;
endmodule

// File: tb/tb_sda_kernel_ctrl_master.sv
// tb_sda_kernel_ctrl_master: randomized self-checking bench with an AXI-Lite slave model.
module tb_sda_kernel_ctrl_master;
    localparam int PG = 15;
    localparam int TO = 100;
    localparam logic [1:0] WR = 2'd0, RD = 2'd1, RUN = 2'd2, RSV = 2'd3;

    typedef struct {logic [31:0] d; logic [1:0] r;} rd_t;

    logic clk = 1'b0, rst_n;
    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0] cmd_op;
    logic [15:0] cmd_addr, awaddr, araddr;
    logic [31:0] cmd_wdata, rsp_rdata, wdata, rdata;
    logic [3:0] wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;

    int n_assert = 0, n_fail = 0, cyc = 0, acc_cyc = 0, rsp_cyc = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] cfg_bresp = 2'b00;
    rd_t rq[$];
    logic [15:0] aw_log[$], ar_log[$];
    logic [31:0] w_log[$];
    logic [3:0] strb_log[$];
    int ar_cyc[$];

    sda_kernel_ctrl_master #(.ADDR_WIDTH(16), .POLL_GAP(PG), .TIMEOUT_CYCLES(TO)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_control_AWADDR(awaddr), .m_axi_control_AWVALID(awvalid), .m_axi_control_AWREADY(awready),
        .m_axi_control_WDATA(wdata), .m_axi_control_WSTRB(wstrb), .m_axi_control_WVALID(wvalid),
        .m_axi_control_WREADY(wready), .m_axi_control_BRESP(bresp), .m_axi_control_BVALID(bvalid),
        .m_axi_control_BREADY(bready), .m_axi_control_ARADDR(araddr), .m_axi_control_ARVALID(arvalid),
        .m_axi_control_ARREADY(arready), .m_axi_control_RDATA(rdata), .m_axi_control_RRESP(rresp),
        .m_axi_control_RVALID(rvalid), .m_axi_control_RREADY(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-side slave: READY pulses for one edge after a delay, B follows both handshakes.
    initial begin : wr_slave
        int ac, wc, bc;
        bit ag, wg, bf;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        ac = 0; wc = 0; bc = 0; ag = 0; wg = 0; bf = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; ac = 0; wc = 0; bc = 0; ag = 0; wg = 0; bf = 0;
            end else begin
                if (awready) begin awready = 0; ag = 1; end
                else if (awvalid) begin
                    if (ac >= aw_dly) begin awready = 1; ac = 0; aw_log.push_back(awaddr); end
                    else ac++;
                end
                if (wready) begin wready = 0; wg = 1; end
                else if (wvalid) begin
                    if (wc >= w_dly) begin
                        wready = 1; wc = 0; w_log.push_back(wdata); strb_log.push_back(wstrb);
                    end else wc++;
                end
                if (bf) begin bvalid = 0; bf = 0; end
                else if (ag && wg && !bvalid) begin
                    if (bc >= b_dly) begin bvalid = 1; bresp = cfg_bresp; bc = 0; ag = 0; wg = 0; end
                    else bc++;
                end
                bf = bvalid && bready;
            end
        end
    end

    // Read-side slave: returns queued status words, or OKAY zero when the queue is empty.
    initial begin : rd_slave
        int arc, rc;
        bit rp, rf;
        rd_t e;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; arc = 0; rc = 0; rp = 0; rf = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; rvalid = 0; arc = 0; rc = 0; rp = 0; rf = 0;
            end else begin
                if (arready) begin arready = 0; rp = 1; rc = 0; end
                else if (arvalid) begin
                    if (arc >= ar_dly) begin
                        arready = 1; arc = 0; ar_log.push_back(araddr); ar_cyc.push_back(cyc);
                    end else arc++;
                end
                if (rf) begin rvalid = 0; rf = 0; end
                else if (rp && !rvalid) begin
                    if (rc >= r_dly) begin
                        rvalid = 1; rp = 0;
                        if (rq.size() > 0) begin e = rq.pop_front(); rdata = e.d; rresp = e.r; end
                        else begin rdata = 0; rresp = 0; end
                    end else rc++;
                end
                rf = rvalid && rready;
            end
        end
    end

    function automatic void model(input logic [1:0] op, input logic [1:0] br, input rd_t s[$],
                                  output int naw, output int nar, output logic [31:0] rd, output logic er);
        naw = 0; nar = 0; rd = 0; er = 0;
        if (op == WR) begin naw = 1; er = (br != 0); end
        else if (op == RD) begin nar = 1; rd = s[0].d; er = (s[0].r != 0); end
        else if (op == RUN) begin
            naw = 1;
            if (br != 0) er = 1;
            else for (int i = 0; i < s.size(); i++) begin
                nar++; rd = s[i].d;
                if (s[i].r != 0) begin er = 1; break; end
                if (s[i].d[1]) break;
            end
        end else er = 1;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
        int t = 0;
        aw_log.delete(); w_log.delete(); strb_log.delete(); ar_log.delete(); ar_cyc.delete();
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_assert++;
        if (t >= 100) begin n_fail++; $display("FAIL cmd_accept: cmd_ready=%b, required 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 0; acc_cyc = cyc;
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] d, output logic e);
        int t = 0;
        while (rsp_valid !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        n_assert++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_wait: rsp_valid=%b, required 1", rsp_valid); end
        rsp_cyc = cyc;
        repeat (hold) @(negedge clk);
        d = rsp_rdata; e = rsp_err;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_assert++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_rdata, awaddr, araddr, wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_rdata, awaddr, araddr, wdata});
        end
        rst_n = 1;
        @(negedge clk);
        n_assert++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_write;
        logic [31:0] d;
        logic e;
        aw_dly = 0; w_dly = 3; b_dly = 1; cfg_bresp = 0;
        send_cmd(WR, 16'h0010, 32'hDEADBEEF);
        n_assert++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cmd_ready_drop: got %b want 0", cmd_ready); end
        get_rsp(0, d, e);
        n_assert++;
        if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL write_rsp: rdata=%h err=%b want 0/0", d, e); end
        n_assert++;
        if (aw_log.size() != 1 || aw_log[0] !== 16'h0010) begin
            n_fail++; $display("FAIL write_aw: n=%0d addr=%h want 1/0010", aw_log.size(), aw_log[0]);
        end
        n_assert++;
        if (w_log.size() != 1 || w_log[0] !== 32'hDEADBEEF || strb_log[0] !== 4'hF) begin
            n_fail++; $display("FAIL write_w: n=%0d data=%h strb=%h want 1/deadbeef/f", w_log.size(), w_log[0], strb_log[0]);
        end
        n_assert++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read;
        logic [31:0] d;
        logic e;
        ar_dly = 1; r_dly = 5;
        rq.delete(); rq.push_back('{32'h12345678, 2'b00});
        send_cmd(RD, 16'h0018, 32'h0);
        get_rsp(1, d, e);
        n_assert++;
        if (d !== 32'h12345678 || e !== 1'b0) begin n_fail++; $display("FAIL read_rsp: rdata=%h err=%b want 12345678/0", d, e); end
        n_assert++;
        if (ar_log.size() != 1 || ar_log[0] !== 16'h0018 || aw_log.size() != 0) begin
            n_fail++; $display("FAIL read_ar: n_ar=%0d addr=%h n_aw=%0d want 1/0018/0", ar_log.size(), ar_log[0], aw_log.size());
        end
    endtask

    task automatic test_run;
        logic [31:0] d;
        logic e;
        bit ok = 1;
        aw_dly = 1; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 2;
        rq.delete(); rq.push_back('{32'h0, 2'b00}); rq.push_back('{32'h0, 2'b00}); rq.push_back('{32'h2, 2'b00});
        send_cmd(RUN, 16'hBEEF, 32'h0);
        get_rsp(0, d, e);
        n_assert++;
        if (d !== 32'h2 || e !== 1'b0) begin n_fail++; $display("FAIL run_rsp: rdata=%h err=%b want 2/0", d, e); end
        n_assert++;
        if (aw_log.size() != 1 || aw_log[0] !== 16'h0 || w_log.size() != 1 || w_log[0] !== 32'h1) begin
            n_fail++; $display("FAIL run_start: n_aw=%0d addr=%h data=%h want 1/0/1", aw_log.size(), aw_log[0], w_log[0]);
        end
        for (int i = 0; i < ar_log.size(); i++) if (ar_log[i] !== 16'h0) ok = 0;
        n_assert++;
        if (ar_log.size() != 3 || !ok) begin n_fail++; $display("FAIL run_polls: n_ar=%0d addr_ok=%0d want 3/1", ar_log.size(), ok); end
        for (int i = 1; i < ar_cyc.size(); i++) begin
            n_assert++;
            if (ar_cyc[i] - ar_cyc[i-1] < PG) begin
                n_fail++; $display("FAIL run_gap: spacing=%0d want >=%0d", ar_cyc[i] - ar_cyc[i-1], PG);
            end
        end
    endtask

    task automatic test_bresp_err;
        logic [31:0] d;
        logic e;
        cfg_bresp = 2'b10;
        send_cmd(WR, 16'h0020, 32'h55AA55AA);
        get_rsp(0, d, e);
        n_assert++;
        if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL write_bresp: err=%b rdata=%h want 1/0", e, d); end
        send_cmd(RUN, 16'h0, 32'h0);
        get_rsp(0, d, e);
        n_assert++;
        if (e !== 1'b1 || ar_log.size() != 0 || aw_log.size() != 1) begin
            n_fail++; $display("FAIL run_bresp: err=%b n_ar=%0d n_aw=%0d want 1/0/1", e, ar_log.size(), aw_log.size());
        end
        cfg_bresp = 2'b00;
    endtask

    task automatic test_reserved;
        logic [31:0] d;
        logic e;
        send_cmd(RSV, 16'h1234, 32'h1);
        get_rsp(0, d, e);
        n_assert++;
        if (e !== 1'b1 || d !== 32'h0 || aw_log.size() != 0 || ar_log.size() != 0) begin
            n_fail++; $display("FAIL reserved_op: err=%b rdata=%h n_aw=%0d n_ar=%0d want 1/0/0/0", e, d, aw_log.size(), ar_log.size());
        end
    endtask

    task automatic test_rsp_hold;
        logic [31:0] d;
        logic e;
        int t = 0;
        ar_dly = 0; r_dly = 0;
        rq.delete(); rq.push_back('{32'hA5A55A5A, 2'b00});
        send_cmd(RD, 16'h0044, 32'h0);
        while (rsp_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A55A5A || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_hold: valid=%b rdata=%h err=%b cmd_ready=%b want 1/a5a55a5a/0/0",
                         rsp_valid, rsp_rdata, rsp_err, cmd_ready);
            end
            @(negedge clk);
        end
        get_rsp(0, d, e);
    endtask

    task automatic test_reset_mid;
        int t = 0;
        ar_dly = 0; r_dly = 40;
        rq.delete(); rq.push_back('{32'h1, 2'b00});
        send_cmd(RD, 16'h0008, 32'h0);
        while (rready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        n_assert++;
        if (rready !== 1'b1) begin n_fail++; $display("FAIL reach_rd_r: rready=%b want 1", rready); end
        rst_n = 0;
        #1;
        n_assert++;
        if ({awvalid, wvalid, arvalid, rready, bready, rsp_valid} !== 6'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: valids=%b cmd_ready=%b want 000000/1",
                               {awvalid, wvalid, arvalid, rready, bready, rsp_valid}, cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1; rq.delete();
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [15:0] a;
        logic [31:0] d, ed, wd;
        logic e, ee;
        int naw, nar, np;
        rd_t s;
        for (int k = 0; k < 25; k++) begin
            op = 2'($urandom_range(3, 0)); a = 16'($urandom); wd = $urandom;
            aw_dly = $urandom_range(3, 0); w_dly = $urandom_range(3, 0); b_dly = $urandom_range(2, 0);
            ar_dly = $urandom_range(3, 0); r_dly = $urandom_range(4, 0);
            cfg_bresp = ($urandom_range(7, 0) == 0) ? 2'b10 : 2'b00;
            rq.delete();
            np = $urandom_range(3, 1);
            for (int i = 0; i < np; i++) begin
                s.d = (i == np - 1) ? ($urandom | 32'h2) : ($urandom & ~32'h2);
                s.r = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
                rq.push_back(s);
            end
            model(op, cfg_bresp, rq, naw, nar, ed, ee);
            send_cmd(op, a, wd);
            get_rsp($urandom_range(3, 0), d, e);
            n_assert++;
            if (d !== ed || e !== ee) begin
                n_fail++; $display("FAIL rand_rsp[%0d] op=%0d: rdata=%h err=%b want %h/%b", k, op, d, e, ed, ee);
            end
            n_assert++;
            if (aw_log.size() != naw || w_log.size() != naw || ar_log.size() != nar) begin
                n_fail++; $display("FAIL rand_count[%0d] op=%0d: aw=%0d w=%0d ar=%0d want %0d/%0d/%0d",
                                   k, op, aw_log.size(), w_log.size(), ar_log.size(), naw, naw, nar);
            end
            if (naw == 1) begin
                n_assert++;
                if (aw_log[0] !== ((op == RUN) ? 16'h0 : a) || w_log[0] !== ((op == RUN) ? 32'h1 : wd)) begin
                    n_fail++; $display("FAIL rand_aw[%0d]: addr=%h data=%h", k, aw_log[0], w_log[0]);
                end
            end
            if (op == RD) begin
                n_assert++;
                if (ar_log[0] !== a) begin n_fail++; $display("FAIL rand_ar[%0d]: addr=%h want %h", k, ar_log[0], a); end
            end
        end
        cfg_bresp = 2'b00;
    endtask

`ifdef SDA_CTRL_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] d;
        logic e;
        int el;
        ar_dly = 0; r_dly = 1; rq.delete();
        send_cmd(RUN, 16'h0, 32'h0);
        get_rsp(0, d, e);
        el = rsp_cyc - acc_cyc;
        n_assert++;
        if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL timeout_rsp: err=%b rdata=%h want 1/0", e, d); end
        n_assert++;
        if (el < TO || el > TO + PG + 20) begin
            n_fail++; $display("FAIL timeout_window: elapsed=%0d want %0d..%0d", el, TO, TO + PG + 20);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        test_reset;
        test_write;
        test_read;
        test_run;
        test_bresp_err;
        test_reserved;
        test_rsp_hold;
        test_reset_mid;
        test_random;
`ifdef SDA_CTRL_MASTER_TIMEOUT_EN
        test_timeout;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sda_kernel_ctrl_master.md
Name: sda_kernel_ctrl_master

Overview: AXI4-Lite initiator that drives an SDAccel kernel's s_axi_control slave from a simple command stream. It issues parameter register writes and reads. It also runs a kernel: writes ap_start at offset 0, then polls offset 0 until ap_done is set. Used in host-side emulation and self-test harnesses as the other end of the kernel control interface.

Parameters:
ADDR_WIDTH, 16, width of AXI-Lite address and cmd_addr
POLL_GAP, 15, idle cycles between successive status polls during RUN (0 = back-to-back)
TIMEOUT_CYCLES, 65535, RUN poll budget in cycles (used only with timeout feature)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=WRITE, 1=READ, 2=RUN, 3=reserved (errors)
cmd_addr  in  ADDR_WIDTH  byte address, WRITE/READ only
cmd_wdata  in  32  write data, WRITE only
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_rdata  out  32  READ data; last status word for RUN; 0 for WRITE
rsp_err  out  1  nonzero BRESP/RRESP, reserved op, or timeout
m_axi_control_AWADDR  out  ADDR_WIDTH  write address
m_axi_control_AWVALID  out  1  write address valid
m_axi_control_AWREADY  in  1  write address ready
m_axi_control_WDATA  out  32  write data
m_axi_control_WSTRB  out  4  always 4'hF
m_axi_control_WVALID  out  1  write data valid
m_axi_control_WREADY  in  1  write data ready
m_axi_control_BRESP  in  2  write response
m_axi_control_BVALID  in  1  write response valid
m_axi_control_BREADY  out  1  write response ready
m_axi_control_ARADDR  out  ADDR_WIDTH  read address
m_axi_control_ARVALID  out  1  read address valid
m_axi_control_ARREADY  in  1  read address ready
m_axi_control_RDATA  in  32  read data
m_axi_control_RRESP  in  2  read response
m_axi_control_RVALID  in  1  read data valid
m_axi_control_RREADY  out  1  read data ready

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State IDLE; poll counter and error flag cleared. Mid-transaction reset abandons the transaction immediately.
- States: IDLE, WR (AW/W pending), WR_B, RD_AR, RD_R, POLL_GAP, RSP.
- IDLE: cmd_ready=1. On accept, cmd_ready drops the next cycle. Address and data are registered.
  - WRITE -> WR. RUN -> WR with addr 0, data 32'h1. READ -> RD_AR. Op 3 -> RSP with rsp_err=1.
- WR: AWVALID and WVALID both assert the cycle after accept. Each deasserts independently on its own handshake. Leave WR for WR_B only after both complete, in either order or the same cycle.
- Payload (AWADDR, WDATA, ARADDR) is stable while the matching VALID is high. No VALID ever waits on a READY.
- WR_B: BREADY=1. On BVALID, err |= (BRESP!=0). WRITE -> RSP. RUN -> RD_AR with addr 0, unless err is set (then RSP).
- RD_AR: ARVALID=1 until ARREADY, then RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA and err |= (RRESP!=0).
  - READ -> RSP.
  - RUN -> RSP if RDATA[1]=1 (ap_done) or err; otherwise POLL_GAP.
- POLL_GAP: count POLL_GAP cycles, then RD_AR. With POLL_GAP=0, go straight to RD_AR.
- RSP: rsp_valid=1, outputs held stable until rsp_ready. Then IDLE, cmd_ready=1 next cycle. Minimum of one idle cycle between commands.
- Only one outstanding AXI transaction at any time. Address width is passed through without truncation.

Optional Feature:
SDA_CTRL_MASTER_TIMEOUT_EN
- Defined: a 32-bit counter clears on RUN accept and increments every cycle in RD_AR/RD_R/POLL_GAP. Reaching TIMEOUT_CYCLES while in POLL_GAP goes to RSP with rsp_err=1 and rsp_rdata = last status word. An in-flight read always completes first.
- Undefined: no counter; RUN polls indefinitely.

Decomposition:
- Package sda_kernel_ctrl_pkg holds:
  - op encodings OP_WRITE/OP_READ/OP_RUN
  - state enum
  - CTRL_REG_OFFSET=0, AP_START_BIT=0, AP_DONE_BIT=1
  - AXI_RESP_OKAY=2'b00
- One sub-module, sda_ctrl_poll_timer: poll-gap/timeout counter with load, tick, expire.

Test Plan:
- WRITE addr 16'h0010 data 32'hDEADBEEF with AWREADY 3 cycles before WREADY -> one AW and one W handshake; rsp_valid with rsp_err=0, rsp_rdata=0.
- READ addr 16'h0018, slave returns 32'h12345678 OKAY after 5-cycle RVALID delay -> rsp_rdata=32'h12345678, rsp_err=0.
- RUN; slave returns status 32'h0 twice, then 32'h2 -> exactly one write of 32'h1 to addr 0, three reads of addr 0 spaced ≥POLL_GAP cycles apart, rsp_rdata=32'h2, rsp_err=0.
- WRITE with BRESP=2'b10 -> rsp_err=1. RUN with BRESP=2'b10 -> no reads issued, rsp_err=1.
- rsp_ready held low 10 cycles -> rsp outputs stable, cmd_ready=0 throughout. Reset asserted mid RD_R -> all VALIDs low immediately, cmd_ready=1.
- With SDA_CTRL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=100, status always 0 -> RSP with rsp_err=1 within 100+POLL_GAP+read latency cycles.
